ps2_kbd_tx: RTL

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

---
 rtl/ps2_kbd_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard device-side transmitter.
// Turns key events (toggle-signalled) into PS/2 make/break byte sequences,
// queues them in a byte FIFO and serialises each byte as an 11-bit frame.
// Ports:
//   clk_sys      : single system clock, rising edge
//   reset        : asynchronous active-high reset
//   ps2_key      : [10] event toggle, [9] pressed, [8] extended, [7:0] scan code
//   ps2_kbd_clk  : PS/2 clock line (device driven, idle high, registered)
//   ps2_kbd_data : PS/2 data line (device driven, idle high, registered)
//   busy         : FIFO non-empty or frame/gap in progress
//   overflow     : one-cycle pulse per dropped event
module ps2_kbd_tx #(
   parameter int unsigned CLK_DIV    = 2500,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   output logic        ps2_kbd_clk,
   output logic        ps2_kbd_data,
   output logic        busy,
   output logic        overflow
);

   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = PW + 1;
   localparam int unsigned DW   = $clog2(4 * CLK_DIV);
   localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST  = DW'(4 * CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

   state_t          state, state_d;
   logic [DW-1:0]   div_cnt, div_d;
   logic [3:0]      bit_cnt, bit_d;
   logic [10:0]     frame, frame_d;
   logic            pop;
   logic            clk_d, data_d, busy_d;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CNTW-1:0] count, count_d, free_cnt;

   logic            tog_q, primed;
   logic            event_c, push, ovf_d;
   logic [7:0]      seq [3];
   logic [1:0]      seq_len;

   // Event detection and expansion into the make/break byte sequence
   always_comb begin
      event_c = primed && (ps2_key[10] != tog_q);
      seq[0]  = ps2_key[7:0];
      seq[1]  = 8'h00;
      seq[2]  = 8'h00;
      seq_len = 2'd1;
      case ({ps2_key[8], ps2_key[9]})
         2'b10: begin seq[0] = 8'hE0; seq[1] = 8'hF0; seq[2] = ps2_key[7:0]; seq_len = 2'd3; end
         2'b11: begin seq[0] = 8'hE0; seq[1] = ps2_key[7:0]; seq_len = 2'd2; end
         2'b00: begin seq[0] = 8'hF0; seq[1] = ps2_key[7:0]; seq_len = 2'd2; end
         default: ;
      endcase
      // Free space uses start-of-cycle occupancy; a concurrent pop does not help
      free_cnt = CNTW'(FIFO_DEPTH) - count;
      push     = event_c && (free_cnt >= CNTW'(seq_len));
      ovf_d    = event_c && !push;
      count_d  = count + (push ? CNTW'(seq_len) : CNTW'(0)) - (pop ? CNTW'(1) : CNTW'(0));
   end

   // FIFO storage, whole sequence written in one cycle
   always_ff @(posedge clk_sys) begin
      if (push) begin
         for (int i = 0; i < 3; i++) begin
            if (2'(i) < seq_len) mem[wr_ptr + PW'(i)] <= seq[i];
         end
      end
   end

   // Next state, frame datapath and next line values
   always_comb begin
      state_d = state;
      div_d   = div_cnt;
      bit_d   = bit_cnt;
      frame_d = frame;
      pop     = 1'b0;
      case (state)
         IDLE: if (count != '0) state_d = LOAD;
         LOAD: begin
            pop     = 1'b1;
            frame_d = {1'b1, ~^mem[rd_ptr], mem[rd_ptr], 1'b0};
            bit_d   = 4'd0;
            div_d   = '0;
            state_d = BIT_HI;
         end
         BIT_HI: begin
            if (div_cnt == HALF_LAST) begin
               div_d   = '0;
               state_d = BIT_LO;
            end else begin
               div_d = div_cnt + DW'(1);
            end
         end
         BIT_LO: begin
            if (div_cnt == HALF_LAST) begin
               div_d = '0;
               if (bit_cnt == 4'd10) begin
                  state_d = GAP;
               end else begin
                  bit_d   = bit_cnt + 4'd1;
                  state_d = BIT_HI;
               end
            end else begin
               div_d = div_cnt + DW'(1);
            end
         end
         GAP: begin
            if (div_cnt == GAP_LAST) begin
               div_d   = '0;
               state_d = IDLE;
            end else begin
               div_d = div_cnt + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Lines are registered from next-state values so they align with state
      clk_d  = (state_d != BIT_LO);
      data_d = ((state_d == BIT_HI) || (state_d == BIT_LO)) ? frame_d[bit_d] : 1'b1;
      busy_d = (count_d != '0) || (state_d != IDLE);
   end

   // State, counters, FIFO pointers and registered outputs
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         frame        <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         tog_q        <= 1'b0;
         primed       <= 1'b0;
         ps2_kbd_clk  <= 1'b1;
         ps2_kbd_data <= 1'b1;
         busy         <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         state        <= state_d;
         div_cnt      <= div_d;
         bit_cnt      <= bit_d;
         frame        <= frame_d;
         count        <= count_d;
         // First cycle after reset only captures the toggle level
         tog_q        <= ps2_key[10];
         primed       <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PW'(seq_len);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         ps2_kbd_clk  <= clk_d;
         ps2_kbd_data <= data_d;
         busy         <= busy_d;
         overflow     <= ovf_d;
      end
   end

endmodule
